// File: rtl/fpu_op_sequencer_if.sv
// rtl/fpu_op_sequencer_if.sv - byte stream, multiplier and status signals of the FP op sequencer
interface fpu_op_sequencer_if;
  logic        flush;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mul_start;
  logic        mul_valid;
  logic [31:0] mul_result;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  op_count;

  // Sequencer side
  modport slave (
    input  flush, byte_in, byte_valid, mul_valid, mul_result, byte_out_ready,
    output byte_ready, op_a, op_b, mul_start, byte_out, byte_out_valid,
           busy, timeout_err, op_count
  );

  // Pin logic / multiplier side
  modport master (
    output flush, byte_in, byte_valid, mul_valid, mul_result, byte_out_ready,
    input  byte_ready, op_a, op_b, mul_start, byte_out, byte_out_valid,
           busy, timeout_err, op_count
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - assembles byte-serial operands, launches one FP multiply, streams the result back
module fpu_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] NAN_VALUE      = 32'h7FC00000
) (
  input logic                clk,
  input logic                rst,
  fpu_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  // Wait counter value on the last permitted WAIT cycle
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] result_q, result_d;
  logic        timeout_err_q, timeout_err_d;
  logic [7:0]  op_count_q, op_count_d;

  logic        byte_fire;
  logic        out_fire;

  // Handshake qualifiers; a flush cycle never accepts an input byte
  assign bus.byte_ready     = (state_q == S_LOAD) && !bus.flush;
  assign bus.byte_out_valid = (state_q == S_DRAIN);
  assign byte_fire          = bus.byte_valid && bus.byte_ready;
  assign out_fire           = bus.byte_out_valid && bus.byte_out_ready;

  // Output decode from registered state
  assign bus.mul_start   = (state_q == S_ISSUE);
  assign bus.busy        = (state_q != S_LOAD);
  assign bus.byte_out    = (state_q == S_DRAIN) ? result_q[{drain_cnt_q, 3'b000} +: 8] : 8'h00;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.op_count    = op_count_q;

  // Next-state and datapath updates; flush overrides every transition
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    result_d      = result_q;
    timeout_err_d = timeout_err_q;
    op_count_d    = op_count_q;

    case (state_q)
      S_LOAD: begin
        if (byte_fire) begin
          // Little-endian: counter bit 2 selects the operand, bits 1:0 the lane
          if (byte_cnt_q[2]) begin
            op_b_d[{byte_cnt_q[1:0], 3'b000} +: 8] = bus.byte_in;
          end else begin
            op_a_d[{byte_cnt_q[1:0], 3'b000} +: 8] = bus.byte_in;
          end
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wait_cnt_d = 16'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mul_valid) begin
          // A result arriving on the expiry cycle still wins over the timeout
          result_d   = bus.mul_result;
          wait_cnt_d = 16'd0;
          state_d    = S_DRAIN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          result_d      = NAN_VALUE;
          timeout_err_d = 1'b1;
          wait_cnt_d    = 16'd0;
          state_d       = S_DRAIN;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          drain_cnt_d = drain_cnt_q + 2'd1;
          if (drain_cnt_q == 2'd3) begin
            op_count_d = op_count_q + 8'd1;
            state_d    = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    if (bus.flush) begin
      state_d       = S_LOAD;
      byte_cnt_d    = 3'd0;
      wait_cnt_d    = 16'd0;
      drain_cnt_d   = 2'd0;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      result_d      = result_q;
      timeout_err_d = timeout_err_q;
      op_count_d    = op_count_q;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LOAD;
      byte_cnt_q    <= 3'd0;
      wait_cnt_q    <= 16'd0;
      drain_cnt_q   <= 2'd0;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      result_q      <= 32'd0;
      timeout_err_q <= 1'b0;
      op_count_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
      op_count_q    <= op_count_d;
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - scoreboard bench for fpu_op_sequencer
module tb_fpu_op_sequencer;
  localparam int unsigned TO  = 8;
  localparam logic [31:0] NAN = 32'h7FC00000;

  logic clk = 1'b0;
  logic rst;

  fpu_op_sequencer_if bus();

  fpu_op_sequencer #(.TIMEOUT_CYCLES(TO), .NAN_VALUE(NAN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          d;   // WAIT cycle on which mul_valid arrives (0 = never)
    logic [31:0] v;
  } plan_t;

  plan_t      plan_q[$];
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;
  bit exp_terr = 1'b0;
  int exp_issues = 0;
  int n_start = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 held low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Consumer ready generation
  initial begin
    bus.byte_out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.byte_out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.byte_out_ready = 1'b1;
        default: bus.byte_out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every output transfer
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mul_start) n_start++;
        if (bus.byte_out_valid && bus.byte_out_ready) begin
          chk("byte_ready_in_drain", {31'd0, bus.byte_ready}, 32'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h expected none", bus.byte_out);
          end else begin
            e = exp_q.pop_front();
            chk("out_byte", {24'd0, bus.byte_out}, {24'd0, e});
          end
        end
      end
    end
  end

  // Multiplier model: checks operands at launch and answers per plan
  initial begin
    plan_t p;
    bus.mul_valid  = 1'b0;
    bus.mul_result = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mul_start) begin
        if (plan_q.size() == 0) begin
          fail_now("unplanned_mul_start");
        end else begin
          p = plan_q.pop_front();
          chk("op_a", bus.op_a, p.a);
          chk("op_b", bus.op_b, p.b);
          if (p.d > 0) begin
            repeat (p.d) @(posedge clk);
            #1;
            bus.mul_valid  = 1'b1;
            bus.mul_result = p.v;
            @(posedge clk); #1;
            bus.mul_valid  = 1'b0;
            bus.mul_result = $urandom;
          end
        end
      end
    end
  end

  // Entered and left at posedge+1
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    @(negedge clk);
    while (!bus.byte_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) fail_now("byte_accept");
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 300) fail_now("return_to_load");
    @(posedge clk); #1;
    chk("op_count", {24'd0, bus.op_count}, {24'd0, 8'(exp_count)});
    chk("timeout_err", {31'd0, bus.timeout_err}, {31'd0, exp_terr});
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  // mode 0 normal, 1 flush during WAIT, 2 output backpressure
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int d,
                        input logic [31:0] v, input int mode);
    plan_t       p;
    logic [31:0] res;
    bit          to;
    int          guard;
    p.a = a; p.b = b; p.d = d; p.v = v;
    plan_q.push_back(p);
    exp_issues++;
    to  = !(d >= 1 && d <= int'(TO));
    res = to ? NAN : v;
    if (mode != 1) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(res[8*k +: 8]);
      exp_count++;
      if (to) exp_terr = 1'b1;
    end
    if (mode == 2) rdy_mode = 2;
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    for (int k = 0; k < 4; k++) send_byte(b[8*k +: 8]);
    @(negedge clk);
    chk("mul_start_after_8th", {31'd0, bus.mul_start}, 32'd1);
    if (mode == 1) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      repeat (8) begin
        @(posedge clk); #1;
      end
    end else if (mode == 2) begin
      guard = 0;
      while (!bus.byte_out_valid && guard < 50) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 50) fail_now("drain_entry");
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'hAA;
      for (int c = 0; c < 5; c++) begin
        chk("bp_byte_out", {24'd0, bus.byte_out}, {24'd0, res[7:0]});
        chk("bp_valid", {31'd0, bus.byte_out_valid}, 32'd1);
        chk("bp_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        @(negedge clk);
      end
      bus.byte_valid = 1'b0;
      rdy_mode = 1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    wait_idle();
  endtask

  task automatic check_reset_values();
    chk("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.byte_out_valid}, 32'd0);
    chk("rst_byte_out", {24'd0, bus.byte_out}, 32'd0);
    chk("rst_mul_start", {31'd0, bus.mul_start}, 32'd0);
    chk("rst_op_a", bus.op_a, 32'd0);
    chk("rst_op_b", bus.op_b, 32'd0);
    chk("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    chk("rst_op_count", {24'd0, bus.op_count}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   r;
    int   d;
    plan_t p;
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed normal multiply: 1.5 * 2.0 = 3.0
    run_op(32'h3FC00000, 32'h40000000, 3, 32'h40400000, 0);
    // Same op with the consumer stalled on the first byte
    run_op(32'h3FC00000, 32'h40000000, 3, 32'h40400000, 2);
    // Result on the last permitted WAIT cycle is still real
    run_op($urandom, $urandom, int'(TO), $urandom, 0);
    // No result at all: NaN and sticky error
    run_op(32'h40000000, 32'h40400000, 0, 32'h0, 0);
    // Result one cycle too late: timeout, late valid ignored in DRAIN
    run_op($urandom, $urandom, int'(TO) + 1, $urandom, 0);

    // Partial operand discarded by flush
    for (int k = 0; k < 3; k++) send_byte(8'($urandom));
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    run_op($urandom, $urandom, 5, $urandom, 0);

    // Flush during WAIT, result arrives afterwards
    run_op($urandom, $urandom, 4, $urandom, 1);

    // Random traffic until the op counter wraps
    rdy_mode = 0;
    while (exp_count < 256) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        run_op($urandom, $urandom, 4, $urandom, 1);
      end else if (r == 1) begin
        d = ($urandom_range(0, 1) == 0) ? 0 : int'(TO) + $urandom_range(1, 2);
        run_op($urandom, $urandom, d, $urandom, 0);
      end else begin
        run_op($urandom, $urandom, $urandom_range(1, int'(TO)), $urandom, 0);
      end
    end
    chk("op_count_wrap", {24'd0, bus.op_count}, 32'd0);

    // Asynchronous reset in the middle of DRAIN
    rdy_mode = 2;
    p.a = $urandom; p.b = $urandom; p.d = 2; p.v = $urandom;
    plan_q.push_back(p);
    exp_issues++;
    for (int k = 0; k < 4; k++) send_byte(p.a[8*k +: 8]);
    for (int k = 0; k < 4; k++) send_byte(p.b[8*k +: 8]);
    r = 0;
    @(negedge clk);
    while (!bus.byte_out_valid && r < 50) begin
      r++;
      @(negedge clk);
    end
    if (r >= 50) fail_now("drain_before_reset");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_values();
    exp_count = 0;
    exp_terr  = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;
    run_op(32'h3FC00000, 32'h40000000, 3, 32'h40400000, 0);

    chk("mul_start_cycles", n_start, exp_issues);
    chk("plans_consumed", plan_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
